// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and owner constants for the memory bus arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int                    WAIT_CNT_W   = 4;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = 4'hF;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - grant selection: M0 priority, M1 starvation counter, owner lock hold
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_i,
    input  logic resp_i,
    input  logic owner_i,
    input  logic owner_lock_i,
    input  logic m0_req_i,
    input  logic m1_req_i,
    output logic grant_m1_o
);

    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  lock_q, lock_d;
    logic                  owner_req;
    logic                  starved;

    always_comb begin
        owner_req = (owner_i == OWNER_M1) ? m1_req_i : m0_req_i;
        starved   = (wait_cnt_q >= WAIT_CNT_W'(MAX_WAIT));
        if (lock_q && owner_req) begin
            grant_m1_o = owner_i;
        end else if (m0_req_i && m1_req_i) begin
            grant_m1_o = starved;
        end else begin
            grant_m1_o = m1_req_i;
        end
    end

    // A lock is a one-shot hint for the very next arbitration; it is dropped there whether used or not.
    always_comb begin
        lock_d     = lock_q;
        wait_cnt_d = wait_cnt_q;
        if (resp_i) begin
            lock_d = owner_lock_i;
        end else if (arb_i) begin
            lock_d = 1'b0;
        end
        if (!m1_req_i) begin
            wait_cnt_d = '0;
        end else if (arb_i) begin
            if (grant_m1_o) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != WAIT_CNT_MAX) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            lock_q     <= lock_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master single-beat memory port arbiter with read latency and ack pulses
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [1:0] LAT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    arb_state_e        state_q, state_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              busy_q, busy_d;
    logic              grant_m1;

    mem_arb_prio #(
        .MAX_WAIT(MAX_WAIT)
    ) u_prio (
        .clk         (clk),
        .reset       (reset),
        .arb_i       (state_q == ST_IDLE),
        .resp_i      (state_q == ST_RESP),
        .owner_i     (owner_q),
        .owner_lock_i((owner_q == OWNER_M1) ? m1_lock : m0_lock),
        .m0_req_i    (m0_req),
        .m1_req_i    (m1_req),
        .grant_m1_o  (grant_m1)
    );

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ST_ISSUE;
                    owner_d = grant_m1;
                    if (grant_m1) begin
                        we_d        = m1_we;
                        mem_addr_d  = m1_addr;
                        mem_wdata_d = m1_wdata;
                    end else begin
                        we_d        = m0_we;
                        mem_addr_d  = m0_addr;
                        mem_wdata_d = m0_wdata;
                    end
                    mem_we_d = we_d;
                end
            end
            ST_ISSUE: begin
                if (we_q || MEM_LAT <= 1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d   = ST_WAIT;
                    lat_cnt_d = LAT_INIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (owner_q == OWNER_M1) begin
                    m1_ack_d = 1'b1;
                    if (!we_q) m1_rdata_d = mem_rdata;
                end else begin
                    m0_ack_d = 1'b1;
                    if (!we_q) m0_rdata_d = mem_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= 2'd0;
            owner_q     <= OWNER_M0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - bench for mem_bus_arbiter at read latencies 1, 3 and 4
module tb_mem_bus_arbiter;

    localparam int NI       = 3;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic       m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [7:0] m0_addr = 8'h0, m0_wdata = 8'h0, m1_addr = 8'h0, m1_wdata = 8'h0;

    logic       m0_ack_w [NI];
    logic       m1_ack_w [NI];
    logic       mem_we_w [NI];
    logic       owner_w  [NI];
    logic       busy_w   [NI];
    logic [7:0] m0_rdata_w  [NI];
    logic [7:0] m1_rdata_w  [NI];
    logic [7:0] mem_addr_w  [NI];
    logic [7:0] mem_wdata_w [NI];
    logic [7:0] mem_rdata_w [NI];

    logic [7:0] mem_arr [NI][256];
    logic [7:0] pipe    [NI][4];
    logic [7:0] ref_mem [256];

    int checks = 0;
    int errors = 0;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [7:0] init_val(int a);
        return 8'((a * 37 + 11) ^ 8'hC3);
    endfunction

    function automatic logic [36:0] outs(int k);
        return {busy_w[k], mem_we_w[k], owner_w[k], m0_ack_w[k], m1_ack_w[k],
                mem_addr_w[k], mem_wdata_w[k], m0_rdata_w[k], m1_rdata_w[k]};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_bus_arbiter #(
            .ADDR_W(8), .DATA_W(8),
            .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .MAX_WAIT(MAX_WAIT)
        ) u_dut (
            .clk(clk), .reset(reset),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_lock(m0_lock), .m0_ack(m0_ack_w[g]), .m0_rdata(m0_rdata_w[g]),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_lock(m1_lock), .m1_ack(m1_ack_w[g]), .m1_rdata(m1_rdata_w[g]),
            .mem_addr(mem_addr_w[g]), .mem_we(mem_we_w[g]), .mem_wdata(mem_wdata_w[g]),
            .mem_rdata(mem_rdata_w[g]), .owner(owner_w[g]), .busy(busy_w[g])
        );
    end

    // Memory model: address pipeline gives data MEM_LAT cycles after the address appears.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                for (int a = 0; a < 256; a++) mem_arr[k][a] <= init_val(a);
            end else if (mem_we_w[k]) begin
                mem_arr[k][mem_addr_w[k]] <= mem_wdata_w[k];
            end
            pipe[k][0] <= mem_addr_w[k];
            for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) mem_rdata_w[k] = mem_arr[k][pipe[k][lat_of(k)-1]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 8'h0; m0_wdata = 8'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 8'h0; m1_wdata = 8'h0;
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        tick();
    endtask

    task automatic wait_m0_ack(input int k, output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = m0_ack_w[k];
        end
        if (!seen) n = -1;
        m0_req = 1'b0;
    endtask

    task automatic test_reset();
        int  n;
        bit  stray;
        do_reset();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (outs(k) !== 37'h0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %h expected 0", k, outs(k));
            end
        end
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h40;
        tick();
        tick();
        checks++;
        if (busy_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_wait: got %b expected 1", busy_w[1]);
        end
        reset = 1'b1;
        m0_req = 1'b0;
        #1;
        checks++;
        if (outs(1) !== 37'h0) begin
            errors++;
            $display("FAIL async_reset_read: got %h expected 0", outs(1));
        end
        tick();
        tick();
        reset = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            tick();
            if (m0_ack_w[1] || m1_ack_w[1] || busy_w[1]) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL ack_after_reset: got 1 expected 0");
        end
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h40;
        wait_m0_ack(1, n);
        checks++;
        if (n != 2 + lat_of(1)) begin
            errors++;
            $display("FAIL read_after_reset_latency: got %0d expected %0d", n, 2 + lat_of(1));
        end
        checks++;
        if (m0_rdata_w[1] !== ref_mem[8'h40]) begin
            errors++;
            $display("FAIL read_after_reset_data: got %h expected %h", m0_rdata_w[1], ref_mem[8'h40]);
        end
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h41; m0_wdata = 8'h99;
        tick();
        checks++;
        if (mem_we_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL we_in_issue: got %b expected 1", mem_we_w[1]);
        end
        reset = 1'b1;
        m0_req = 1'b0;
        #1;
        checks++;
        if (mem_we_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_we: got %b expected 0", mem_we_w[1]);
        end
        do_reset();
    endtask

    task automatic test_write();
        int n, ack_n, we_cycles;
        bit m1_seen;
        logic [7:0] we_addr, we_data;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h20; m0_wdata = 8'hA5;
        n = 0; ack_n = -1; we_cycles = 0; m1_seen = 1'b0; we_addr = 8'h0; we_data = 8'h0;
        repeat (8) begin
            tick();
            n++;
            if (mem_we_w[0]) begin
                we_cycles++;
                we_addr = mem_addr_w[0];
                we_data = mem_wdata_w[0];
            end
            if (m1_ack_w[0]) m1_seen = 1'b1;
            if (m0_ack_w[0] && ack_n < 0) begin
                ack_n = n;
                m0_req = 1'b0;
            end
        end
        ref_mem[8'h20] = 8'hA5;
        checks++;
        if (ack_n != 3) begin errors++; $display("FAIL write_ack_cycle: got %0d expected 3", ack_n); end
        checks++;
        if (we_cycles != 1) begin errors++; $display("FAIL write_we_cycles: got %0d expected 1", we_cycles); end
        checks++;
        if (we_addr !== 8'h20) begin errors++; $display("FAIL write_addr: got %h expected 20", we_addr); end
        checks++;
        if (we_data !== 8'hA5) begin errors++; $display("FAIL write_data: got %h expected a5", we_data); end
        checks++;
        if (m1_seen) begin errors++; $display("FAIL write_m1_ack: got 1 expected 0"); end
    endtask

    task automatic test_read();
        int n;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 8'h3C;
        wait_m0_ack(0, n);
        ref_mem[8'h10] = 8'h3C;
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        wait_m0_ack(0, n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL read_ack_cycle: got %0d expected 3", n); end
        checks++;
        if (m0_rdata_w[0] !== 8'h3C) begin errors++; $display("FAIL read_data: got %h expected 3c", m0_rdata_w[0]); end
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h20;
        wait_m0_ack(0, n);
        checks++;
        if (m0_rdata_w[0] !== ref_mem[8'h20]) begin
            errors++;
            $display("FAIL readback_data: got %h expected %h", m0_rdata_w[0], ref_mem[8'h20]);
        end
    endtask

    task automatic test_latency();
        int  n;
        int  ack_n [NI];
        bit  we_seen;
        logic [7:0] rd [NI];
        do_reset();
        for (int k = 0; k < NI; k++) begin ack_n[k] = -1; rd[k] = 8'h0; end
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'hFF;
        n = 0; we_seen = 1'b0;
        while (ack_n[2] < 0 && n < 20) begin
            tick();
            n++;
            if (mem_we_w[2]) we_seen = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (m0_ack_w[k] && ack_n[k] < 0) begin
                    ack_n[k] = n;
                    rd[k] = m0_rdata_w[k];
                end
            end
        end
        m0_req = 1'b0;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (ack_n[k] != 2 + lat_of(k)) begin
                errors++;
                $display("FAIL lat%0d_ack_cycle: got %0d expected %0d", lat_of(k), ack_n[k], 2 + lat_of(k));
            end
            checks++;
            if (rd[k] !== ref_mem[8'hFF]) begin
                errors++;
                $display("FAIL lat%0d_rdata: got %h expected %h", lat_of(k), rd[k], ref_mem[8'hFF]);
            end
        end
        checks++;
        if (we_seen) begin errors++; $display("FAIL lat4_mem_we: got 1 expected 0"); end
    endtask

    task automatic test_priority_random();
        logic [7:0] addr_t [2];
        logic [7:0] wdata_t [2];
        bit         we_t [2];
        bit         lock_t [2];
        int         exp_owner, exp_wait, acks, cyc, m;
        bit         a0, a1, prev_lock;
        logic [7:0] rd;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            we_t[i] = 1'($urandom_range(0, 1)); addr_t[i] = 8'($urandom);
            wdata_t[i] = 8'($urandom); lock_t[i] = 1'b0;
        end
        m0_we = we_t[0]; m0_addr = addr_t[0]; m0_wdata = wdata_t[0]; m0_lock = lock_t[0];
        m1_we = we_t[1]; m1_addr = addr_t[1]; m1_wdata = wdata_t[1]; m1_lock = lock_t[1];
        m0_req = 1'b1; m1_req = 1'b1;
        exp_owner = 0;
        exp_wait  = 1;
        acks = 0; cyc = 0;
        while (acks < 40 && cyc < 2000) begin
            tick();
            cyc++;
            a0 = m0_ack_w[0];
            a1 = m1_ack_w[0];
            if (a0 || a1) begin
                m = a1 ? 1 : 0;
                checks++;
                if (a0 && a1) begin errors++; $display("FAIL both_acks at ack %0d", acks); end
                checks++;
                if (m != exp_owner) begin
                    errors++;
                    $display("FAIL grant_order[%0d]: got M%0d expected M%0d", acks, m, exp_owner);
                end
                checks++;
                if (owner_w[0] !== 1'(m)) begin
                    errors++;
                    $display("FAIL owner_out[%0d]: got %b expected %0d", acks, owner_w[0], m);
                end
                if (!we_t[m]) begin
                    rd = m ? m1_rdata_w[0] : m0_rdata_w[0];
                    checks++;
                    if (rd !== ref_mem[addr_t[m]]) begin
                        errors++;
                        $display("FAIL arb_rdata[%0d]: got %h expected %h", acks, rd, ref_mem[addr_t[m]]);
                    end
                end else begin
                    ref_mem[addr_t[m]] = wdata_t[m];
                end
                prev_lock = lock_t[m];
                if (prev_lock) exp_owner = m;
                else exp_owner = (exp_wait >= MAX_WAIT) ? 1 : 0;
                if (exp_owner == 1) exp_wait = 0;
                else if (exp_wait < 15) exp_wait++;
                acks++;
                we_t[m] = 1'($urandom_range(0, 1)); addr_t[m] = 8'($urandom);
                wdata_t[m] = 8'($urandom);
                lock_t[m] = (acks >= 15) ? ($urandom_range(0, 2) == 0) : 1'b0;
                if (m == 0) begin
                    m0_we = we_t[0]; m0_addr = addr_t[0]; m0_wdata = wdata_t[0]; m0_lock = lock_t[0];
                end else begin
                    m1_we = we_t[1]; m1_addr = addr_t[1]; m1_wdata = wdata_t[1]; m1_lock = lock_t[1];
                end
            end
        end
        checks++;
        if (acks < 40) begin errors++; $display("FAIL arb_timeout: got %0d acks expected 40", acks); end
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    endtask

    task automatic test_lock();
        int         seq [$];
        int         m1_cnt, cyc;
        int         exp_seq [4] = '{1, 1, 1, 0};
        logic [7:0] cur1, cur0;
        do_reset();
        cur1 = 8'($urandom); cur0 = 8'($urandom);
        m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1; m1_addr = cur1;
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = cur0;
        m1_cnt = 0; cyc = 0;
        while (seq.size() < 4 && cyc < 200) begin
            tick();
            cyc++;
            if (m1_ack_w[1]) begin
                seq.push_back(1);
                checks++;
                if (m1_rdata_w[1] !== ref_mem[cur1]) begin
                    errors++;
                    $display("FAIL lock_m1_rdata[%0d]: got %h expected %h", m1_cnt, m1_rdata_w[1], ref_mem[cur1]);
                end
                m1_cnt++;
                if (m1_cnt < 3) begin cur1 = 8'($urandom); m1_addr = cur1; end
                else m1_req = 1'b0;
            end
            if (m0_ack_w[1]) begin
                seq.push_back(0);
                checks++;
                if (m0_rdata_w[1] !== ref_mem[cur0]) begin
                    errors++;
                    $display("FAIL lock_m0_rdata: got %h expected %h", m0_rdata_w[1], ref_mem[cur0]);
                end
                m0_req = 1'b0;
            end
        end
        checks++;
        if (seq.size() != 4) begin
            errors++;
            $display("FAIL lock_ack_count: got %0d expected 4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seq[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL lock_order[%0d]: got M%0d expected M%0d", i, seq[i], exp_seq[i]);
                end
            end
        end
        m1_lock = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_latency();
        test_priority_random();
        test_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
